// File: rtl/seg_scroll_message.sv
// Scrolling message feeder for a 4-digit multiplexed 7-segment controller.
// A small character buffer is written while idle. The message then scrolls
// right-to-left across the four digits, one frame every TICK_DIV cycles.
module seg_scroll_message #(
  parameter int          MAX_LEN    = 16,
  parameter int          TICK_DIV   = 25000000,
  parameter logic [4:0]  BLANK_CODE = 5'h1F
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
  input  logic [4:0]               wr_char,
  input  logic [$clog2(MAX_LEN):0] msg_len,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic                     done,
  output logic [19:0]              seg_data
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int FW = $clog2(MAX_LEN + 3);
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t        state, state_nx;
  logic [FW-1:0] frame, frame_nx;
  logic [TW-1:0] tick_cnt, tick_nx;
  logic [AW:0]   len_r, len_nx;
  logic          loop_r, loop_nx;
  logic          done_nx;
  logic [4:0]    buffer [MAX_LEN];
  logic [19:0]   seg_nx;

  logic accept;
  logic tick_wrap;
  logic last_frame;

  // A start is only honoured with a usable length and no concurrent stop.
  assign accept     = start && !stop && (msg_len != '0) && (int'(msg_len) <= MAX_LEN);
  assign tick_wrap  = (tick_cnt == TW'(TICK_DIV - 1));
  assign last_frame = (int'(frame) == int'(len_r) + 2);
  assign busy       = (state == SCROLL);

  // Next-state logic: stop beats any frame advance or end of pass.
  always_comb begin
    state_nx = state;
    frame_nx = frame;
    tick_nx  = tick_cnt;
    len_nx   = len_r;
    loop_nx  = loop_r;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SCROLL;
          frame_nx = '0;
          tick_nx  = '0;
          len_nx   = msg_len;
          loop_nx  = loop;
        end
      end
      SCROLL: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (tick_wrap) begin
          tick_nx = '0;
          if (last_frame) begin
            if (loop_r) begin
              frame_nx = '0;
            end else begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end
          end else begin
            frame_nx = frame + FW'(1);
          end
        end else begin
          tick_nx = tick_cnt + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      frame    <= '0;
      tick_cnt <= '0;
      len_r    <= '0;
      loop_r   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      frame    <= frame_nx;
      tick_cnt <= tick_nx;
      len_r    <= len_nx;
      loop_r   <= loop_nx;
      done     <= done_nx;
    end
  end

  // Message buffer: writable only while idle so a pass never changes mid-scroll.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) buffer[i] <= BLANK_CODE;
    end else if (wr_en && (state == IDLE)) begin
      buffer[wr_addr] <= wr_char;
    end
  end

  // Digit k shows character frame-k; the signed index turns positions left of
  // the message start (negative) or past its end into blanks.
  always_comb begin
    int idx;
    idx    = 0;
    seg_nx = {4{BLANK_CODE}};
    if (state == SCROLL) begin
      for (int k = 0; k < 4; k++) begin
        idx = int'(frame) - k;
        if ((idx >= 0) && (idx < int'(len_r))) begin
          seg_nx[k*5 +: 5] = buffer[idx[AW-1:0]];
        end
      end
    end
  end

  // Registered display bus, one edge behind the frame state.
  always_ff @(posedge clk) begin
    if (!reset) seg_data <= {4{BLANK_CODE}};
    else        seg_data <= seg_nx;
  end

endmodule

// File: tb/tb_seg_scroll_message.sv
// Bench for seg_scroll_message: directed scenarios followed by random traffic,
// all checked every cycle against a time-based reference model.
module tb_seg_scroll_message;

  localparam int         MAX_LEN  = 16;
  localparam int         TICK_DIV = 4;
  localparam logic [4:0] B        = 5'h1F;

  logic        clk = 1'b0;
  logic        reset, wr_en, loop, start, stop;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_char, msg_len;
  logic        busy, done;
  logic [19:0] seg_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the display is a function of edges elapsed since start.
  logic [4:0] m_buf [MAX_LEN];
  bit         m_active;
  bit         m_loop;
  bit         m_done;
  int         m_j;
  int         m_len;
  logic [19:0] exp_seg;

  always #5 clk = ~clk;

  seg_scroll_message #(.MAX_LEN(MAX_LEN), .TICK_DIV(TICK_DIV), .BLANK_CODE(B)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .msg_len(msg_len), .loop(loop), .start(start), .stop(stop),
    .busy(busy), .done(done), .seg_data(seg_data)
  );

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] disp();
    logic [19:0] r;
    int s, d;
    r = {4{B}};
    if (m_active) begin
      s = m_j / TICK_DIV;
      if (m_loop) s = s % (m_len + 3);
      for (int k = 0; k < 4; k++) begin
        d = s - k;
        if (d >= 0 && d < m_len) r[k*5 +: 5] = m_buf[d];
      end
    end
    return r;
  endfunction

  // Advance model and DUT across one rising edge, then compare all outputs.
  task automatic step();
    logic [19:0] pre;
    pre = disp();
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) m_buf[i] = B;
      m_active = 0; m_done = 0; m_j = 0;
      pre = {4{B}};
    end else begin
      m_done = 0;
      if (m_active) begin
        if (stop) m_active = 0;
        else begin
          m_j++;
          if (!m_loop && m_j == (m_len + 3) * TICK_DIV) begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end else begin
        if (wr_en) m_buf[wr_addr] = wr_char;
        if (start && !stop && int'(msg_len) >= 1 && int'(msg_len) <= MAX_LEN) begin
          m_active = 1; m_j = 0; m_len = int'(msg_len); m_loop = loop;
        end
      end
    end
    exp_seg = pre;
    @(posedge clk);
    #1;
    chk("seg_data", seg_data, exp_seg);
    chk("busy", {19'd0, busy}, {19'd0, m_active});
    chk("done", {19'd0, done}, {19'd0, m_done});
  endtask

  task automatic quiet();
    start = 0; stop = 0; wr_en = 0;
  endtask

  task automatic run(input int n);
    quiet();
    repeat (n) step();
  endtask

  task automatic go(input int len, input bit lp);
    quiet();
    msg_len = 5'(len); loop = lp; start = 1;
    step();
    start = 0;
  endtask

  task automatic wr(input int a, input int c);
    quiet();
    wr_en = 1; wr_addr = 4'(a); wr_char = 5'(c);
    step();
    wr_en = 0;
  endtask

  initial begin
    reset = 0; wr_en = 0; wr_addr = '0; wr_char = '0; msg_len = '0;
    loop = 0; start = 0; stop = 0;
    m_active = 0; m_loop = 0; m_done = 0; m_j = 0; m_len = 0;
    repeat (2) step();
    reset = 1;
    run(3);
    chk("reset_seg", seg_data, 20'hFFFFF);

    // Blank buffer scrolled in full.
    go(16, 0);
    run(80);

    // Three-character single pass, with literal frame checks.
    wr(0, 5'h01); wr(1, 5'h02); wr(2, 5'h03);
    go(3, 0);
    run(1);
    chk("plan_f0", seg_data, 20'hFFFE1);
    run(4);
    chk("plan_f1", seg_data, {B, B, 5'h01, 5'h02});
    run(24);

    // Looping for more than three passes, then stop.
    go(3, 1);
    run(80);
    stop = 1; step(); stop = 0;
    run(4);

    // Stop during frame 2, then restart.
    go(3, 0);
    run(9);
    stop = 1; step(); stop = 0;
    run(3);
    go(3, 0);
    run(30);

    // Out-of-range lengths are ignored.
    go(0, 0); run(3);
    go(17, 0); run(3);

    // Writes during scroll are ignored; next pass shows the old content.
    go(3, 0);
    wr_en = 1; wr_addr = 4'd1; wr_char = 5'h05;
    repeat (6) step();
    run(24);
    go(3, 0);
    run(28);

    // Write in the same cycle as start, then reset mid-scroll.
    quiet();
    wr_en = 1; wr_addr = 4'd0; wr_char = 5'h07; msg_len = 5'd3; loop = 0; start = 1;
    step();
    run(1);
    chk("same_cycle_wr", seg_data, {B, B, B, 5'h07});
    run(6);
    reset = 0; step(); reset = 1;
    run(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(199) != 0);
      wr_en   = ($urandom_range(3) == 0);
      wr_addr = 4'($urandom);
      wr_char = 5'($urandom);
      start   = ($urandom_range(9) == 0);
      stop    = ($urandom_range(59) == 0);
      msg_len = 5'($urandom_range(18));
      loop    = 1'($urandom);
      step();
    end
    reset = 1;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scroll_message.md
Name: seg_scroll_message

Overview:
- Upstream feeder for the 4-digit multiplexed 7-segment controller.
- Holds a message of up to MAX_LEN 5-bit character codes written by control logic.
- Scrolls the message right-to-left across the 4 digits at a programmable frame rate.
- Drives the controller's 20-bit seg_data bus: digit 3 in [19:15] (leftmost), digit 0 in [4:0] (rightmost).

Parameters:
- MAX_LEN, 16, message buffer depth in characters; power of 2, minimum 4.
- TICK_DIV, 25000000, clk cycles per scroll frame; minimum 2.
- BLANK_CODE, 5'h1F, character code shown in empty digit positions.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  1  write one character into the buffer.
- wr_addr  in  log2(MAX_LEN)  buffer index to write.
- wr_char  in  5  character code to write.
- msg_len  in  log2(MAX_LEN)+1  message length; sampled only when start is accepted.
- loop  in  1  1 = repeat scrolling forever; 0 = single pass; sampled when start is accepted.
- start  in  1  single-cycle request to begin scrolling.
- stop  in  1  abort scrolling.
- busy  out  1  high while in SCROLL.
- done  out  1  one-cycle pulse at the end of a non-looping pass.
- seg_data  out  20  4 x 5-bit character codes to the display controller; registered.

Behaviour:
- Reset (reset=0 at an edge):
  - buffer entries all = BLANK_CODE; state = IDLE; frame = 0; tick_cnt = 0.
  - busy = 0; done = 0; seg_data = {4{BLANK_CODE}}.
- States are IDLE and SCROLL.
- Writes:
  - Accepted only in IDLE: buf[wr_addr] <= wr_char at the edge.
  - wr_en in SCROLL is ignored; the buffer is unchanged.
- IDLE to SCROLL:
  - Taken when start=1, stop=0, and 1 <= msg_len <= MAX_LEN.
  - Otherwise start is ignored and the block stays IDLE (msg_len=0 or msg_len>MAX_LEN also ignored).
  - At the accepting edge N: latch len and loop_r; frame <= 0; tick_cnt <= 0; busy <= 1.
  - A write in the same cycle as start completes at edge N and is visible in frame 0.
- Frame content: for frame s, digit k (k=0 rightmost .. 3 leftmost) shows buf[s-k] if 0 <= s-k < len, else BLANK_CODE.
  - Valid frames are 0 .. len+2, i.e. len+3 frames per pass.
  - Frame 0 = {B,B,B,c0}; final frame = {c(len-1),B,B,B}.
- seg_data registered: it reflects the current state/frame one edge later. Frame 0 appears at edge N+1.
- Tick counter:
  - In SCROLL, tick_cnt increments each cycle.
  - At tick_cnt == TICK_DIV-1 it wraps to 0 and the frame advances.
  - Frame s therefore ends at edge N+(s+1)*TICK_DIV.
- End of final frame (s = len+2 at the advancing edge):
  - loop_r=1: frame <= 0 and scrolling continues seamlessly; no done pulse.
  - loop_r=0: state <= IDLE; busy <= 0; done <= 1 for exactly one cycle; seg_data blank from the next edge.
- Stop:
  - stop=1 in SCROLL: state <= IDLE and busy <= 0 at that edge; no done pulse.
  - seg_data becomes all BLANK_CODE one edge later.
  - stop has priority over a simultaneous frame advance or end of pass.
  - stop=1 in IDLE blocks start in the same cycle.
- start while in SCROLL is ignored; no restart.
- Changes on msg_len and loop after start has been accepted have no effect.
- Reset asserted mid-scroll returns everything to reset values at that edge; done is not pulsed.
- Widths:
  - frame counter is log2(MAX_LEN+3) rounded up.
  - The index s-k is computed signed or with a guard so that negative values map to BLANK_CODE.

Test Plan (TICK_DIV=4, MAX_LEN=16, B=5'h1F):
- Reset, then hold reset=1 -> seg_data=20'hFFFFF, busy=0, done=0; buf[0..15] read back blank when scrolled.
- Write buf[0..2]={01,02,03}; start with msg_len=3, loop=0 at edge N:
  - Frames at N+1, +5, +9, +13, +17, +21 are {B,B,B,01}, {B,B,01,02}, {B,01,02,03}, {01,02,03,B}, {02,03,B,B}, {03,B,B,B}.
  - done=1 only in the cycle after edge N+24; busy=0 and seg_data blank afterwards.
- Same message with loop=1 -> after {03,B,B,B} the next frame is {B,B,B,01}; done never asserts over 3 passes.
- stop asserted during frame 2 -> busy=0 next cycle; seg_data blank one edge later; no done pulse; a new start is then accepted.
- start with msg_len=0, and separately with msg_len=17 -> busy stays 0 and seg_data stays blank. wr_en with wr_char=5'h05 during SCROLL -> buffer unchanged on the next pass.
- start and wr_en(addr 0, 5'h07) in the same cycle -> frame 0 shows {B,B,B,07}. reset=0 mid-scroll -> all outputs return to reset values at that edge.
